// File: rtl/frame_ram_arbiter_if.sv
// Client-side bus of the frame RAM arbiter: motion-compensation client 0 (read/write),
// display client 1 (read only), and the shared read-return data.
interface frame_ram_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 8
);
  logic          req0;
  logic          we0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          gnt0;
  logic          rvalid0;

  logic          req1;
  logic [AW-1:0] addr1;
  logic          gnt1;
  logic          rvalid1;

  logic [DW-1:0] rdata;

  modport master (
    output req0, we0, addr0, wdata0, req1, addr1,
    input  gnt0, rvalid0, gnt1, rvalid1, rdata
  );

  modport slave (
    input  req0, we0, addr0, wdata0, req1, addr1,
    output gnt0, rvalid0, gnt1, rvalid1, rdata
  );
endinterface

// File: rtl/frame_ram_arbiter.sv
// Round-robin arbiter with a burst cap sharing one single-port frame RAM between two clients.
// Registers the RAM command and steers the read-return valid back to the issuing client.
module frame_ram_arbiter #(
  parameter int AW        = 16,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4,
  parameter int RAM_LAT   = 1
) (
  input  logic                CLK,
  input  logic                reset,
  frame_ram_arbiter_if.slave  bus,
  output logic                ram_we,
  output logic [AW-1:0]       ram_addr,
  output logic [DW-1:0]       ram_din,
  input  logic [DW-1:0]       ram_dout
);

  if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_burst
    $error("MAX_BURST must be in 1..15");
  end
  if (RAM_LAT < 1 || RAM_LAT > 3) begin : g_bad_lat
    $error("RAM_LAT must be in 1..3");
  end

  localparam logic [3:0] CAP = 4'(MAX_BURST);

  function automatic logic [3:0] sat_inc(input logic [3:0] cnt);
    sat_inc = (cnt >= CAP) ? CAP : cnt + 4'd1;
  endfunction

  logic       r_prio;
  logic       r_last;
  logic [3:0] r_burst_cnt;

  logic       w_gnt0;
  logic       w_gnt1;
  logic       w_xfer;
  logic       w_win;
  logic       w_prio_nxt;
  logic       w_last_nxt;
  logic [3:0] w_cnt_nxt;

  // Arbitration state register
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_prio      <= 1'b0;
      r_last      <= 1'b0;
      r_burst_cnt <= 4'd0;
    end else begin
      r_prio      <= w_prio_nxt;
      r_last      <= w_last_nxt;
      r_burst_cnt <= w_cnt_nxt;
    end
  end

  // Next arbitration state: a client switch restarts the burst and hands it priority until its cap
  always_comb begin
    w_xfer     = w_gnt0 | w_gnt1;
    w_win      = w_gnt1;
    w_prio_nxt = r_prio;
    w_last_nxt = r_last;
    w_cnt_nxt  = r_burst_cnt;
    if (w_xfer) begin
      if (w_win == r_last) begin
        w_cnt_nxt = sat_inc(r_burst_cnt);
      end else begin
        w_cnt_nxt  = 4'd1;
        w_last_nxt = w_win;
      end
      if (w_cnt_nxt >= CAP) begin
        w_prio_nxt = ~w_win;
      end else if (w_win != r_last) begin
        w_prio_nxt = w_win;
      end
    end
  end

  // Grant outputs: a lone requester always wins, prio only breaks ties
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (reset) begin
      if (bus.req0 && bus.req1) begin
        w_gnt0 = ~r_prio;
        w_gnt1 = r_prio;
      end else begin
        w_gnt0 = bus.req0;
        w_gnt1 = bus.req1;
      end
    end
  end

  assign bus.gnt0 = w_gnt0;
  assign bus.gnt1 = w_gnt1;

  logic          r_we_p0;
  logic [AW-1:0] r_addr_p0;
  logic [DW-1:0] r_din_p0;
  logic          r_vld_p0;
  logic          r_id_p0;

  // Stage p0: registered RAM command, tagged with read-valid and client id
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_we_p0   <= 1'b0;
      r_addr_p0 <= '0;
      r_din_p0  <= '0;
      r_vld_p0  <= 1'b0;
      r_id_p0   <= 1'b0;
    end else begin
      r_we_p0  <= 1'b0;
      r_vld_p0 <= 1'b0;
      if (w_gnt0) begin
        r_we_p0   <= bus.we0;
        r_addr_p0 <= bus.addr0;
        r_din_p0  <= bus.wdata0;
        r_vld_p0  <= ~bus.we0;
        r_id_p0   <= 1'b0;
      end else if (w_gnt1) begin
        r_addr_p0 <= bus.addr1;
        r_din_p0  <= '0;
        r_vld_p0  <= 1'b1;
        r_id_p0   <= 1'b1;
      end
    end
  end

  assign ram_we   = r_we_p0;
  assign ram_addr = r_addr_p0;
  assign ram_din  = r_din_p0;

  logic [RAM_LAT-1:0] r_vld_p1;
  logic [RAM_LAT-1:0] r_id_p1;

  // Stage p1: read-return tag pipeline matched to the RAM read latency
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_vld_p1 <= '0;
      r_id_p1  <= '0;
    end else begin
      r_vld_p1[0] <= r_vld_p0;
      r_id_p1[0]  <= r_id_p0;
      for (int i = 1; i < RAM_LAT; i++) begin
        r_vld_p1[i] <= r_vld_p1[i-1];
        r_id_p1[i]  <= r_id_p1[i-1];
      end
    end
  end

  assign bus.rvalid0 = r_vld_p1[RAM_LAT-1] & ~r_id_p1[RAM_LAT-1];
  assign bus.rvalid1 = r_vld_p1[RAM_LAT-1] &  r_id_p1[RAM_LAT-1];
  assign bus.rdata   = ram_dout;

endmodule

// File: tb/tb_frame_ram_arbiter.sv
// Scoreboard bench for frame_ram_arbiter: drivers push expected grants, writes and read
// returns into queues; a negedge monitor pops and compares whenever the DUT presents them.
module tb_frame_ram_arbiter;
  localparam int AW = 16;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic rst3_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  frame_ram_arbiter_if #(.AW(AW), .DW(DW)) ifc ();
  frame_ram_arbiter_if #(.AW(AW), .DW(DW)) ifc3 ();

  logic          ram_we, ram_we3;
  logic [AW-1:0] ram_addr, ram_addr3;
  logic [DW-1:0] ram_din, ram_din3, ram_dout;
  logic [DW-1:0] ram_dout3;
  assign ram_dout3 = 8'h00;

  frame_ram_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(4), .RAM_LAT(1)) u_dut (
    .CLK(clk), .reset(rst_n), .bus(ifc.slave),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  frame_ram_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(4), .RAM_LAT(3)) u_dut3 (
    .CLK(clk), .reset(rst3_n), .bus(ifc3.slave),
    .ram_we(ram_we3), .ram_addr(ram_addr3), .ram_din(ram_din3), .ram_dout(ram_dout3)
  );

  // RAM model, latency 1: preload pattern until a location is written
  function automatic logic [7:0] pat(input logic [7:0] a);
    if (a == 8'h20) return 8'h11;
    if (a == 8'h30) return 8'h22;
    return a ^ 8'hA5;
  endfunction

  logic [7:0] mem [256];
  bit         written [256];
  always @(posedge clk) begin
    ram_dout <= written[ram_addr[7:0]] ? mem[ram_addr[7:0]] : pat(ram_addr[7:0]);
    if (ram_we) begin
      mem[ram_addr[7:0]]     <= ram_din;
      written[ram_addr[7:0]] <= 1'b1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct { bit id; logic [7:0] data; int due; } rd_t;
  typedef struct { logic [15:0] a; logic [7:0] d; } wr_t;
  rd_t rdq[$];
  wr_t wrq[$];
  bit  gq[$];

  // Monitor
  always @(negedge clk) begin
    rd_t er;
    wr_t ew;
    bit  eg;
    if (rst_n === 1'b1) begin
      if (ifc.gnt0 || ifc.gnt1) begin
        check("gnt_exclusive", 32'(ifc.gnt0 & ifc.gnt1), 0);
        if (gq.size() == 0) check("gnt_unexpected", 1, 0);
        else begin
          eg = gq.pop_front();
          check("gnt_order", 32'(ifc.gnt1), 32'(eg));
        end
      end
      if (ifc.rvalid0 || ifc.rvalid1) begin
        check("rvalid_exclusive", 32'(ifc.rvalid0 & ifc.rvalid1), 0);
        if (rdq.size() == 0) check("rvalid_unexpected", 1, 0);
        else begin
          er = rdq.pop_front();
          check("rvalid_id", 32'(ifc.rvalid1), 32'(er.id));
          check("rdata", 32'(ifc.rdata), 32'(er.data));
          check("rvalid_latency", 32'(cyc), 32'(er.due));
        end
      end
      if (ram_we) begin
        if (wrq.size() == 0) check("ram_we_unexpected", 1, 0);
        else begin
          ew = wrq.pop_front();
          check("ram_addr", 32'(ram_addr), 32'(ew.a));
          check("ram_din", 32'(ram_din), 32'(ew.d));
        end
      end
    end
  end

  task automatic c0_xfer(input logic we, input logic [15:0] a, input logic [7:0] d,
                         input logic [7:0] ed);
    bit got = 0;
    ifc.req0 = 1'b1; ifc.we0 = we; ifc.addr0 = a; ifc.wdata0 = d;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (ifc.gnt0) begin got = 1; break; end
    end
    if (!got) begin
      check("c0_grant_timeout", 1, 0);
      ifc.req0 = 1'b0;
      return;
    end
    @(posedge clk); #1;
    ifc.req0 = 1'b0;
    if (we) wrq.push_back('{a: a, d: d});
    else    rdq.push_back('{id: 1'b0, data: ed, due: cyc + 1});
  endtask

  task automatic c1_xfer(input logic [15:0] a, input logic [7:0] ed);
    bit got = 0;
    ifc.req1 = 1'b1; ifc.addr1 = a;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (ifc.gnt1) begin got = 1; break; end
    end
    if (!got) begin
      check("c1_grant_timeout", 1, 0);
      ifc.req1 = 1'b0;
      return;
    end
    @(posedge clk); #1;
    ifc.req1 = 1'b0;
    rdq.push_back('{id: 1'b1, data: ed, due: cyc + 1});
  endtask

  task automatic drain();
    for (int n = 0; n < 50 && (rdq.size() != 0 || wrq.size() != 0 || gq.size() != 0); n++)
      @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
  endtask

  logic [7:0] single_exp [10] = '{8'hA5, 8'hA4, 8'hA7, 8'hA6, 8'hA1,
                                  8'hA0, 8'hA3, 8'hA2, 8'hAD, 8'hAC};

  initial begin
    int viol;
    rst_n = 1'b0; rst3_n = 1'b0;
    ifc.req0 = 1'b1; ifc.we0 = 1'b0; ifc.addr0 = '0; ifc.wdata0 = '0;
    ifc.req1 = 1'b1; ifc.addr1 = '0;
    ifc3.req0 = 1'b0; ifc3.we0 = 1'b0; ifc3.addr0 = '0; ifc3.wdata0 = '0;
    ifc3.req1 = 1'b0; ifc3.addr1 = '0;

    // Reset then idle: grants held off while reset is low
    @(negedge clk);
    check("rst_gnt0", 32'(ifc.gnt0), 0);
    check("rst_gnt1", 32'(ifc.gnt1), 0);
    check("rst_ram_we", 32'(ram_we), 0);
    check("rst_ram_addr", 32'(ram_addr), 0);
    check("rst_ram_din", 32'(ram_din), 0);
    check("rst_rvalid", 32'({ifc.rvalid0, ifc.rvalid1}), 0);
    repeat (2) @(posedge clk);
    #1 ifc.req0 = 1'b0; ifc.req1 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; rst3_n = 1'b1;
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ram_we !== 1'b0 || ifc.gnt0 !== 1'b0 || ifc.gnt1 !== 1'b0 ||
          ifc.rvalid0 !== 1'b0 || ifc.rvalid1 !== 1'b0) viol++;
    end
    check("idle_quiet_cycles", 32'(viol), 0);
    @(posedge clk); #1;

    // Client 0 write 0x5A @0x0010 then read it back
    gq.push_back(1'b0); gq.push_back(1'b0);
    c0_xfer(1'b1, 16'h0010, 8'h5A, 8'h00);
    c0_xfer(1'b0, 16'h0010, 8'h00, 8'h5A);
    drain();

    // Contention from reset: 0,0,0,0,1,1,1,1,0,0,0,0,1,1,1,1
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 16; i++) gq.push_back(((i / 4) % 2) == 1);
    fork
      begin
        for (int i = 0; i < 8; i++) c0_xfer(1'b0, 16'h0040 + 16'(i), 8'h00, pat(8'h40 + 8'(i)));
      end
      begin
        for (int i = 0; i < 8; i++) c1_xfer(16'h0050 + 16'(i), pat(8'h50 + 8'(i)));
      end
    join
    drain();

    // Single requester: client 1 reads addresses 0..9 back to back
    for (int i = 0; i < 10; i++) gq.push_back(1'b1);
    for (int i = 0; i < 10; i++) c1_xfer(16'(i), single_exp[i]);
    drain();

    // Interleaved single requests: R0@0x20 (0x11), R1@0x30 (0x22)
    for (int i = 0; i < 2; i++) begin
      gq.push_back(1'b0); gq.push_back(1'b1);
      c0_xfer(1'b0, 16'h0020, 8'h00, 8'h11);
      c1_xfer(16'h0030, 8'h22);
    end
    drain();

    // Mid-flight reset on the RAM_LAT=3 instance
    @(posedge clk); #1;
    ifc3.req1 = 1'b1; ifc3.addr1 = 16'h0001;
    @(negedge clk);
    check("m3_gnt1_first", 32'(ifc3.gnt1), 1);
    @(posedge clk); #1 ifc3.addr1 = 16'h0002;
    @(negedge clk);
    check("m3_gnt1_second", 32'(ifc3.gnt1), 1);
    @(posedge clk); #1 ifc3.req1 = 1'b0;
    @(posedge clk); #1 rst3_n = 1'b0;
    ifc3.req0 = 1'b1; ifc3.we0 = 1'b0; ifc3.addr0 = 16'h0003; ifc3.req1 = 1'b1;
    @(negedge clk);
    check("m3_rst_gnt", 32'({ifc3.gnt0, ifc3.gnt1}), 0);
    check("m3_rst_rvalid", 32'({ifc3.rvalid0, ifc3.rvalid1}), 0);
    check("m3_rst_ram_we", 32'(ram_we3), 0);
    check("m3_rst_ram_addr", 32'(ram_addr3), 0);
    check("m3_rst_ram_din", 32'(ram_din3), 0);
    @(posedge clk); #1 rst3_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("m3_gnt0_seq", 32'(ifc3.gnt0), 32'(k < 4));
      check("m3_gnt1_seq", 32'(ifc3.gnt1), 32'(k == 4));
      if (k < 4) check("m3_no_stale_rvalid", 32'({ifc3.rvalid0, ifc3.rvalid1}), 0);
    end
    @(posedge clk); #1 ifc3.req0 = 1'b0; ifc3.req1 = 1'b0;
    repeat (6) @(posedge clk);

    check("rd_queue_empty", 32'(rdq.size()), 0);
    check("wr_queue_empty", 32'(wrq.size()), 0);
    check("gnt_queue_empty", 32'(gq.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
